// File: rtl/dualport_mem_slave_if.sv
// Bus between a dualport_bus master and a memory slave: one read and one write port.
// Handshake (both ports): the master raises req with addr/be (and wr_data) stable and
// holds them until the slave pulses gnt for exactly one cycle; req may stay high after
// the gnt cycle to start the next access, and dropping req before gnt aborts the access.
interface dualport_mem_slave_if;
  logic        rd_req;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_gnt;
  logic        wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_gnt;

  modport master (
    output rd_req, rd_be, rd_addr,
    input  rd_data, rd_gnt,
    output wr_req, wr_be, wr_addr, wr_data,
    input  wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr,
    output rd_data, rd_gnt,
    input  wr_req, wr_be, wr_addr, wr_data,
    output wr_gnt
  );
endinterface

// File: rtl/dualport_mem_slave.sv
// Word-organised memory slave with independent read and write ports.
// Each port runs an IDLE/WAIT/DONE FSM with a 4-bit wait-state counter; the array
// is touched only on the edge that enters DONE. Same-word collisions are write-first.
module dualport_mem_slave #(
  parameter int    DEPTH     = 1024,
  parameter int    RD_LAT    = 1,
  parameter int    WR_LAT    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  dualport_mem_slave_if.slave  bus,
  output logic [1:0]           o_rd_state,
  output logic [1:0]           o_wr_state
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] RD_CNT_INIT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_CNT_INIT = 4'(WR_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [31:0]   r_mem [DEPTH];

  state_t        r_rd_state, w_rd_state_nxt;
  state_t        r_wr_state, w_wr_state_nxt;
  logic [3:0]    r_rd_cnt, w_rd_cnt_nxt;
  logic [3:0]    r_wr_cnt, w_wr_cnt_nxt;
  logic [31:0]   r_rd_data;

  logic          w_rd_enter;
  logic          w_wr_enter;
  logic [IW-1:0] w_rd_idx;
  logic [IW-1:0] w_wr_idx;
  logic [31:0]   w_wr_merged;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_rd_mask;
  logic          w_unused_addr;

  // Byte-lane merge: lanes with be set take the new word, the rest keep the old one.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    lane_merge = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) lane_merge[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  // Word index only; byte offset and bits above the array size alias away.
  assign w_rd_idx      = bus.rd_addr[IW+1:2];
  assign w_wr_idx      = bus.wr_addr[IW+1:2];
  assign w_unused_addr = &{1'b0, bus.rd_addr[31:IW+2], bus.rd_addr[1:0],
                           bus.wr_addr[31:IW+2], bus.wr_addr[1:0]};

  // State and counter registers for both ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_state <= S_IDLE;
      r_wr_state <= S_IDLE;
      r_rd_cnt   <= 4'd0;
      r_wr_cnt   <= 4'd0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_wr_state <= w_wr_state_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
    end
  end

  // Read-port next state: dropping req while waiting aborts back to IDLE.
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_cnt_nxt   = r_rd_cnt;
    case (r_rd_state)
      S_IDLE: begin
        if (bus.rd_req) begin
          w_rd_cnt_nxt   = RD_CNT_INIT;
          w_rd_state_nxt = (RD_LAT == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.rd_req) begin
          w_rd_state_nxt = S_IDLE;
          w_rd_cnt_nxt   = 4'd0;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt - 4'd1;
          if (r_rd_cnt == 4'd1) w_rd_state_nxt = S_DONE;
        end
      end
      default: w_rd_state_nxt = S_IDLE;
    endcase
  end

  // Write-port next state: same shape as the read port with its own latency.
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    case (r_wr_state)
      S_IDLE: begin
        if (bus.wr_req) begin
          w_wr_cnt_nxt   = WR_CNT_INIT;
          w_wr_state_nxt = (WR_LAT == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.wr_req) begin
          w_wr_state_nxt = S_IDLE;
          w_wr_cnt_nxt   = 4'd0;
        end else begin
          w_wr_cnt_nxt = r_wr_cnt - 4'd1;
          if (r_wr_cnt == 4'd1) w_wr_state_nxt = S_DONE;
        end
      end
      default: w_wr_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state: gnt is high for the single DONE cycle.
  always_comb begin
    bus.rd_gnt = (r_rd_state == S_DONE);
    bus.wr_gnt = (r_wr_state == S_DONE);
    o_rd_state = r_rd_state;
    o_wr_state = r_wr_state;
  end

  assign w_rd_enter  = (r_rd_state != S_DONE) && (w_rd_state_nxt == S_DONE);
  assign w_wr_enter  = (r_wr_state != S_DONE) && (w_wr_state_nxt == S_DONE);
  assign w_wr_merged = lane_merge(r_mem[w_wr_idx], bus.wr_data, bus.wr_be);
  // Write-first: a write landing on the same word in the same edge is forwarded.
  assign w_rd_word   = (w_wr_enter && (w_wr_idx == w_rd_idx)) ? w_wr_merged
                                                               : r_mem[w_rd_idx];
  assign w_rd_mask   = {{8{bus.rd_be[3]}}, {8{bus.rd_be[2]}},
                        {8{bus.rd_be[1]}}, {8{bus.rd_be[0]}}};

  // Array update on DONE entry; reset held across the edge suppresses the commit.
  always_ff @(posedge clk) begin
    if (w_wr_enter && !rst) r_mem[w_wr_idx] <= w_wr_merged;
  end

  // Read data captured on DONE entry and held until the next read completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= 32'h0;
    end else if (w_rd_enter) begin
      r_rd_data <= w_rd_word & w_rd_mask;
    end
  end

  assign bus.rd_data = r_rd_data;

endmodule
